sdram_burst_arbiter: RTL
========================

Name: sdram_burst_arbiter

Overview:
- Sits directly upstream of the team's SDRAM controller. Arbitrates between two clients:
  - the UART pixel-write path, whose single words are packed into 8-word bursts;
  - the VGA line-fetch path, which requests 8-word read bursts.
- Drives the controller's enable/rw/addr/data handshake and forwards read words back to the VGA side.

Parameters:
- WordLength, 16, data word width
- AddressWidth, 24, word address width ({bank[1:0], row[12:0], col[8:0]})
- BurstLength, 8, words per SDRAM burst; power of two
- StarveMax, 4, consecutive read grants allowed while the write buffer is full before a write is forced

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- i_wr_valid  in  1  UART word write request
- o_wr_ready  out  1  write word accepted when valid&&ready
- i_wr_addr  in  AddressWidth  word address
- i_wr_data  in  WordLength  word data
- i_rd_req  in  1  VGA burst read request, level, held until o_rd_ack
- i_rd_addr  in  AddressWidth  burst base address; low log2(BurstLength) bits ignored
- o_rd_ack  out  1  one-cycle pulse: read request granted
- o_rd_data  out  WordLength  read word
- o_rd_valid  out  1  o_rd_data valid this cycle
- o_rd_done  out  1  one-cycle pulse after the last read word
- o_sd_enable  out  1  controller command request
- o_sd_rw  out  1  0 write, 1 read
- o_sd_addr  out  AddressWidth  burst base address, low bits zero
- o_sd_wdata  out  WordLength  write word for the controller
- i_sd_rdata  in  WordLength  controller read word
- i_sd_valid  in  1  controller word strobe; one per burst word
- i_sd_busy  in  1  controller busy

Behaviour:
- Reset values: all outputs 0 except o_wr_ready=1. State=IDLE, write buffer empty, starve counter 0.
- Write packing:
  - An 8-entry buffer stores each accepted word at index i_wr_addr[2:0].
  - The base address is latched as {i_wr_addr[23:3],3'b000} on the first word of a block.
  - A 4-bit fill count increments per accepted word. At count==BurstLength the buffer is FULL.
  - o_wr_ready = !FULL && state!=W_XFER.
  - A word whose base differs from the latched base while the buffer is partially filled is still accepted into its index. The buffer then holds mixed data. This is a client protocol violation; the client must write aligned sequential blocks.
  - There are no partial bursts and no flush.
- States: IDLE, ISSUE, XFER, DRAIN.
- IDLE:
  - If i_rd_req and (!FULL or starve<StarveMax): grant read. Pulse o_rd_ack, latch the read base, starve++ if FULL. Go to ISSUE with rw=1.
  - Else if FULL: grant write, starve=0, go to ISSUE with rw=0.
  - Else stay in IDLE.
- ISSUE:
  - Hold o_sd_enable=1, o_sd_rw and o_sd_addr stable.
  - On the first cycle with i_sd_busy=1: drop o_sd_enable next cycle, clear word index, go to XFER.
- XFER, write:
  - o_sd_wdata = buf[idx], combinational from the 3-bit idx.
  - idx increments on each i_sd_valid.
  - On the BurstLength-th valid: clear fill count (buffer empty), go to DRAIN.
- XFER, read:
  - o_rd_data=i_sd_rdata and o_rd_valid=i_sd_valid, registered (one-cycle latency).
  - On the 8th valid: pulse o_rd_done, aligned with the registered last word; go to DRAIN.
  - Valid strobes beyond 8 in one burst are ignored.
- DRAIN: wait for i_sd_busy==0, then go to IDLE. No new command is issued before the controller has returned to idle.
- Simultaneous events:
  - rd_req and FULL in the same IDLE cycle resolve per the starve rule.
  - A word accepted in the same cycle a write is granted is impossible, because FULL already blocks o_wr_ready.
- Reset mid-burst: immediate return to the reset values. Buffer contents are discarded and any pending read is not acknowledged.

Decomposition:
- Shared package sdram_pkg:
  - address field widths and offsets (bank 2, row 13, col 9);
  - BurstLength;
  - rw encoding constants (WRITE=0, READ=1);
  - state encodings.
- One sub-module: sdram_wr_packer (8-entry buffer, base latch, fill count, FULL, indexed read port).

Test Plan:
- Reset, then write words 0x1000..0x1007 to addresses 0x000010..0x000017:
  - o_wr_ready drops after the 8th word;
  - ISSUE shows rw=0, addr=0x000010;
  - with 8 valid strobes, o_sd_wdata sequences 0x1000..0x1007;
  - after busy falls, o_wr_ready=1.
- i_rd_req with rd_addr=0x0001A5:
  - o_rd_ack pulses once and o_sd_addr=0x0001A0;
  - controller model returns 0xA0..0xA7;
  - o_rd_valid shows 8 words, each one cycle after its strobe;
  - o_rd_done coincides with 0xA7.
- Write buffer FULL plus continuous rd_req: exactly 4 read bursts are granted, then one write burst, then reads resume.
- Controller holds busy low for 20 cycles in ISSUE: o_sd_enable stays 1 and addr is stable throughout; no strobes are counted.
- Assert RST during the 4th strobe of a read burst:
  - all outputs return to reset values immediately, o_rd_done never pulses;
  - after release, a new request is handled normally.
- Controller emits 10 valid strobes in a read burst: only 8 o_rd_valid pulses occur, and the FSM waits in DRAIN until busy falls.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter slice: address layout, burst size,
// rw encoding and arbiter state encoding.
package sdram_pkg;

  localparam int BANK_W   = 2;
  localparam int ROW_W    = 13;
  localparam int COL_W    = 9;
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = COL_LSB + COL_W;
  localparam int BANK_LSB = ROW_LSB + ROW_W;
  localparam int ADDR_W   = BANK_W + ROW_W + COL_W;

  localparam int BURST_LEN = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sd_addr_t;

  function automatic sd_addr_t split_addr(input logic [ADDR_W-1:0] a);
    sd_addr_t f;
    f.bank = a[BANK_LSB +: BANK_W];
    f.row  = a[ROW_LSB +: ROW_W];
    f.col  = a[COL_LSB +: COL_W];
    return f;
  endfunction

endpackage

// File: rtl/sdram_wr_packer.sv
// Collects single UART words into one burst-sized block; exposes the block base,
// a FULL flag and an indexed read port for the burst transfer.
module sdram_wr_packer
  import sdram_pkg::*;
#(
  parameter int WordLength   = 16,
  parameter int AddressWidth = ADDR_W,
  parameter int BurstLength  = BURST_LEN,
  localparam int IDXW        = $clog2(BurstLength)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_en,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [WordLength-1:0]   wr_data,
  input  logic                    clear,
  input  logic [IDXW-1:0]         rd_idx,
  output logic [WordLength-1:0]   rd_data,
  output logic [AddressWidth-1:0] base,
  output logic                    full
);

  localparam int CNTW = IDXW + 1;
  localparam logic [AddressWidth-1:0] ALIGN_MASK = ~(AddressWidth'(BurstLength - 1));

  logic [WordLength-1:0] buf_mem [BurstLength];
  logic [CNTW-1:0]       fill;

  // Buffer contents are data only; an empty fill count marks them stale.
  always_ff @(posedge CLK) begin
    if (wr_en) buf_mem[wr_addr[IDXW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fill <= '0;
      base <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (wr_en) begin
      fill <= fill + 1'b1;
      if (fill == '0) base <= wr_addr & ALIGN_MASK;
    end
  end

  assign full    = (fill == CNTW'(BurstLength));
  assign rd_data = buf_mem[rd_idx];

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates UART write bursts against VGA read bursts in front of the SDRAM
// controller, with a starvation limit that forces a write after StarveMax reads.
module sdram_burst_arbiter
  import sdram_pkg::*;
#(
  parameter int WordLength   = 16,
  parameter int AddressWidth = ADDR_W,
  parameter int BurstLength  = BURST_LEN,
  parameter int StarveMax    = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [AddressWidth-1:0] i_wr_addr,
  input  logic [WordLength-1:0]   i_wr_data,
  input  logic                    i_rd_req,
  input  logic [AddressWidth-1:0] i_rd_addr,
  output logic                    o_rd_ack,
  output logic [WordLength-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_done,
  output logic                    o_sd_enable,
  output logic                    o_sd_rw,
  output logic [AddressWidth-1:0] o_sd_addr,
  output logic [WordLength-1:0]   o_sd_wdata,
  input  logic [WordLength-1:0]   i_sd_rdata,
  input  logic                    i_sd_valid,
  input  logic                    i_sd_busy
);

  localparam int IDXW = $clog2(BurstLength);
  localparam int CNTW = IDXW + 1;
  localparam int STW  = $clog2(StarveMax + 1);
  localparam logic [AddressWidth-1:0] ALIGN_MASK = ~(AddressWidth'(BurstLength - 1));

  state_t                  state, state_nx;
  logic                    rw_q;
  logic [AddressWidth-1:0] addr_q;
  logic [CNTW-1:0]         beat;
  logic [STW-1:0]          starve;
  logic                    rd_ack_q;
  logic [WordLength-1:0]   rd_data_p1;
  logic                    vld_p1, done_p1;

  logic                    full, wr_en, rd_grant, wr_grant, xfer_vld, beat_last;
  logic [AddressWidth-1:0] wr_base;
  logic [WordLength-1:0]   buf_rdata;

  assign o_wr_ready = !full && !(state == ST_XFER && rw_q == RW_WRITE);
  assign wr_en      = i_wr_valid && o_wr_ready;
  assign rd_grant   = (state == ST_IDLE) && i_rd_req && (!full || starve < STW'(StarveMax));
  assign wr_grant   = (state == ST_IDLE) && !rd_grant && full;
  assign xfer_vld   = (state == ST_XFER) && i_sd_valid;
  assign beat_last  = xfer_vld && (beat == CNTW'(BurstLength - 1));

  sdram_wr_packer #(
    .WordLength  (WordLength),
    .AddressWidth(AddressWidth),
    .BurstLength (BurstLength)
  ) u_packer (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (wr_en),
    .wr_addr(i_wr_addr),
    .wr_data(i_wr_data),
    .clear  (beat_last && rw_q == RW_WRITE),
    .rd_idx (beat[IDXW-1:0]),
    .rd_data(buf_rdata),
    .base   (wr_base),
    .full   (full)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (rd_grant || wr_grant) state_nx = ST_ISSUE;
      ST_ISSUE: if (i_sd_busy)            state_nx = ST_XFER;
      ST_XFER:  if (beat_last)            state_nx = ST_DRAIN;
      ST_DRAIN: if (!i_sd_busy)           state_nx = ST_IDLE;
      default:                            state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rw_q     <= RW_WRITE;
      addr_q   <= '0;
      starve   <= '0;
      beat     <= '0;
      rd_ack_q <= 1'b0;
    end else begin
      rd_ack_q <= rd_grant;
      if (rd_grant) begin
        rw_q   <= RW_READ;
        addr_q <= i_rd_addr & ALIGN_MASK;
        if (full) starve <= starve + 1'b1;
      end else if (wr_grant) begin
        rw_q   <= RW_WRITE;
        addr_q <= wr_base;
        starve <= '0;
      end
      if (state == ST_ISSUE && i_sd_busy) beat <= '0;
      else if (xfer_vld)                  beat <= beat + 1'b1;
    end
  end

  // Stage p1: read words returned one cycle after the controller strobe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      vld_p1  <= xfer_vld && rw_q == RW_READ;
      done_p1 <= beat_last && rw_q == RW_READ;
      if (xfer_vld && rw_q == RW_READ) rd_data_p1 <= i_sd_rdata;
    end
  end

  assign o_rd_ack    = rd_ack_q;
  assign o_rd_data   = rd_data_p1;
  assign o_rd_valid  = vld_p1;
  assign o_rd_done   = done_p1;
  assign o_sd_enable = (state == ST_ISSUE);
  assign o_sd_rw     = rw_q;
  assign o_sd_addr   = addr_q;
  assign o_sd_wdata  = (state == ST_XFER && rw_q == RW_WRITE) ? buf_rdata : '0;

endmodule
